// File: rtl/vmx_chain_feeder_if.sv
// Stream, config and PE-entry signals between a word source and the chain feeder.
// The slave modport is the feeder side; master is the driving side.
interface vmx_chain_feeder_if #(
  parameter int VEC_W = 16
);
  logic             cfg_start;
  logic             cfg_simd_mode;
  logic [VEC_W-1:0] cfg_num_vec;
  logic [15:0]      s_data;
  logic             s_valid;
  logic             s_ready;
  logic [15:0]      pe_data;
  logic             pe_is_weight;
  logic             pe_simd_mode;
  logic             busy;
  logic             done;

  modport master (
    output cfg_start, cfg_simd_mode, cfg_num_vec, s_data, s_valid,
    input  s_ready, pe_data, pe_is_weight, pe_simd_mode, busy, done
  );

  modport slave (
    input  cfg_start, cfg_simd_mode, cfg_num_vec, s_data, s_valid,
    output s_ready, pe_data, pe_is_weight, pe_simd_mode, busy, done
  );
endinterface

// File: rtl/vmx_chain_feeder.sv
// Feeds a systolic PE chain: NUM_PE weight words, num_vec data words, then
// NUM_PE bubble cycles so partial sums drain before done.
module vmx_chain_feeder #(
  parameter int NUM_PE = 8,
  parameter int VEC_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  vmx_chain_feeder_if.slave  bus
);
  localparam int CW = $clog2(NUM_PE + 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, FLUSH, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_wcnt;
  logic [CW-1:0]    r_fcnt;
  logic [VEC_W-1:0] r_vcnt;
  logic [VEC_W-1:0] r_nvec;
  logic [15:0]      r_data;
  logic             r_isw;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;

  logic w_ready, w_acc, w_wlast, w_vlast, w_flast;

  assign w_ready = (r_state == LOAD_W) || (r_state == STREAM);
  assign w_acc   = w_ready && bus.s_valid;
  assign w_wlast = (r_wcnt == CW'(NUM_PE - 1));
  // One extra bit so num_vec = 2^VEC_W-1 terminates without wrapping.
  assign w_vlast = (({1'b0, r_vcnt} + (VEC_W+1)'(1)) == {1'b0, r_nvec});
  assign w_flast = (r_fcnt == CW'(NUM_PE - 1));

  assign bus.s_ready      = w_ready;
  assign bus.pe_data      = r_data;
  assign bus.pe_is_weight = r_isw;
  assign bus.pe_simd_mode = r_mode;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_fcnt  <= '0;
      r_vcnt  <= '0;
      r_nvec  <= '0;
      r_data  <= '0;
      r_isw   <= 1'b0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Non-accepting cycles become zero bubbles on the chain entry.
      r_data <= w_acc ? bus.s_data : 16'h0000;
      r_isw  <= w_acc && (r_state == LOAD_W);
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cfg_start) begin
            r_mode  <= bus.cfg_simd_mode;
            r_nvec  <= bus.cfg_num_vec;
            r_wcnt  <= '0;
            r_vcnt  <= '0;
            r_fcnt  <= '0;
            r_busy  <= 1'b1;
            r_state <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (w_acc) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (w_wlast) r_state <= (r_nvec == '0) ? FLUSH : STREAM;
          end
        end
        STREAM: begin
          if (w_acc) begin
            r_vcnt <= r_vcnt + 1'b1;
            if (w_vlast) r_state <= FLUSH;
          end
        end
        FLUSH: begin
          r_fcnt <= r_fcnt + 1'b1;
          if (w_flast) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
